instr_seq: RTL



---
 rtl/instr_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/instr_seq.sv
// Instruction sequencer: IDLE/FETCH/EXEC/HALTED control FSM with a one-hot
// instruction decoder, a sticky illegal-encoding flag and an executed-instruction counter.
module instr_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ir,
    input  logic        start,
    input  logic        step_mode,
    output logic        mova,
    output logic        movb,
    output logic        movc,
    output logic        add,
    output logic        sub,
    output logic        and1,
    output logic        not1,
    output logic        rsr,
    output logic        rsl,
    output logic        jmp,
    output logic        jz,
    output logic        jc,
    output logic        in1,
    output logic        out1,
    output logic        nop,
    output logic        halt,
    output logic        sm,
    output logic        run,
    output logic        illegal,
    output logic [15:0] icount
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_e;

    // Bit positions in the internal one-hot decode vector.
    localparam int F_MOVA = 0,  F_MOVB = 1,  F_MOVC = 2,  F_ADD  = 3;
    localparam int F_SUB  = 4,  F_AND  = 5,  F_NOT  = 6,  F_RSR  = 7;
    localparam int F_RSL  = 8,  F_JMP  = 9,  F_JZ   = 10, F_JC   = 11;
    localparam int F_IN   = 12, F_OUT  = 13, F_NOP  = 14, F_HALT = 15;

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [15:0] icount_q, icount_d;

    logic [15:0] dec;
    logic        dec_ill;
    logic [15:0] flags;
    logic [1:0]  fd, fs;

    assign fd = ir[3:2];
    assign fs = ir[1:0];

    always_comb begin
        dec     = '0;
        dec_ill = 1'b0;
        case (ir[7:4])
            4'hF: begin
                if (fd != 2'b11 && fs != 2'b11)      dec[F_MOVA] = 1'b1;
                else if (fd == 2'b11 && fs != 2'b11) dec[F_MOVB] = 1'b1;
                else if (fd != 2'b11)                dec[F_MOVC] = 1'b1;
                else                                 dec_ill     = 1'b1;
            end
            4'h9: dec[F_ADD] = 1'b1;
            4'h6: dec[F_SUB] = 1'b1;
            4'hB: dec[F_AND] = 1'b1;
            4'h5: dec[F_NOT] = 1'b1;
            4'hA: begin
                if (fs == 2'b00)      dec[F_RSR] = 1'b1;
                else if (fs == 2'b11) dec[F_RSL] = 1'b1;
                else                  dec_ill    = 1'b1;
            end
            4'h3: begin
                case (ir[3:0])
                    4'h0:    dec[F_JMP] = 1'b1;
                    4'h1:    dec[F_JZ]  = 1'b1;
                    4'h2:    dec[F_JC]  = 1'b1;
                    default: dec_ill    = 1'b1;
                endcase
            end
            4'h2:    dec[F_IN]   = 1'b1;
            4'h4:    dec[F_OUT]  = 1'b1;
            4'h7:    dec[F_NOP]  = 1'b1;
            4'h8:    dec[F_HALT] = 1'b1;
            default: dec_ill     = 1'b1;
        endcase
        // Illegal encodings execute as a nop so the machine keeps moving.
        if (dec_ill) dec[F_NOP] = 1'b1;
    end

    assign sm    = (state_q == S_EXEC) || (state_q == S_HALTED);
    assign run   = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign flags = sm ? dec : 16'h0000;

    assign {halt, nop, out1, in1, jc, jz, jmp, rsl,
            rsr, not1, and1, sub, add, movc, movb, mova} = flags;

    assign illegal = illegal_q;
    assign icount  = icount_q;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        icount_d  = icount_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                icount_d = icount_q + 16'd1;
                if (dec_ill) illegal_d = 1'b1;
                if (dec[F_HALT])    state_d = S_HALTED;
                else if (step_mode) state_d = S_IDLE;
                else                state_d = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            icount_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            icount_q  <= icount_d;
        end
    end

endmodule
